spi_cmd_seq: RTL

//  Command sequencer sitting directly upstream of the SPI master transmitter.

---
 rtl/spi_cmd_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/spi_cmd_seq.sv
// Command FIFO in front of the SPI master: queues {pos,w8,data} words and
// launches them one at a time, waiting for the transmitter's done to cycle.
module spi_cmd_seq #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_vld,
  input  logic [15:0]   cmd_data,
  input  logic          cmd_w8,
  input  logic          cmd_pos,
  output logic          cmd_rdy,
  input  logic          flush,
  input  logic          spi_done,
  output logic          spi_wrt,
  output logic [15:0]   spi_tx_data,
  output logic          spi_width8,
  output logic          spi_pos_edge,
  output logic          busy,
  output logic [AW:0]   cmd_cnt,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_LO, WAIT_HI} state_e;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          rdy_q, busy_q, ovf_q, wrt_q, w8_q, pos_q;
  logic [15:0]   data_q;
  logic [17:0]   mem_q [DEPTH];
  logic [17:0]   head;
  logic          full, pop, push;

  assign head = mem_q[rptr_q];
  assign full = (cnt_q == FULL_CNT);
  // Launch consumes the head; flush suppresses it so nothing new starts that cycle.
  assign pop  = (state_q == IDLE) && (cnt_q != '0) && spi_done && !flush;
  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign push = cmd_vld && !flush && (!full || pop);

  always_comb begin
    cnt_d = cnt_q;
    if (flush)              cnt_d = '0;
    else if (push && !pop)  cnt_d = cnt_q + CNT_ONE;
    else if (pop && !push)  cnt_d = cnt_q - CNT_ONE;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop)       state_d = LAUNCH;
      LAUNCH:                 state_d = WAIT_LO;
      WAIT_LO: if (!spi_done) state_d = WAIT_HI;
      WAIT_HI: if (spi_done)  state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {cmd_pos, cmd_w8, cmd_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wrt_q   <= 1'b0;
      data_q  <= '0;
      w8_q    <= 1'b0;
      pos_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (cnt_d != FULL_CNT);
      busy_q  <= (cnt_d != '0) || (state_d != IDLE);
      wrt_q   <= pop;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (push)            wptr_q <= wptr_q + PTR_ONE;
        if (pop)             rptr_q <= rptr_q + PTR_ONE;
        if (cmd_vld && !push) ovf_q <= 1'b1;
      end
      // Transaction attributes change only at launch, never mid-packet.
      if (pop) {pos_q, w8_q, data_q} <= head;
    end
  end

  assign cmd_rdy      = rdy_q;
  assign busy         = busy_q;
  assign cmd_cnt      = cnt_q;
  assign overflow     = ovf_q;
  assign spi_wrt      = wrt_q;
  assign spi_tx_data  = data_q;
  assign spi_width8   = w8_q;
  assign spi_pos_edge = pos_q;

endmodule
